vga_box_renderer: RTL and testbench
===================================

Name: vga_box_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA sync generator.
- Consumes its pixel coordinates, video_on, p_tick and raw sync levels.
- Draws a solid square that bounces off the screen edges, one position update per frame, over a background with a one-pixel white frame border.
- Re-times hsync/vsync through the same pipeline as the colour, so the pins going to the DAC/connector stay pixel-aligned.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- V_DISPLAY, 480, visible lines per frame
- SIZE, 32, box edge length in pixels (1..V_DISPLAY)
- SPEED, 2, pixels moved per axis per frame (1..SIZE)
- X0, 0, reset x of box top-left (0..H_DISPLAY-SIZE)
- Y0, 0, reset y of box top-left (0..V_DISPLAY-SIZE)
- COLOR_BOX, 12'hF00, box colour (4:4:4 RGB)
- COLOR_BG, 12'h00F, background colour
- COLOR_BORDER, 12'hFFF, frame-border colour

Ports:
- clk  in  1  system clock (same clock as sync generator)
- reset_n  in  1  asynchronous, active-low reset
- p_tick  in  1  pixel enable, one clk pulse per pixel
- video_on  in  1  visible-area flag from sync generator
- hsync_in  in  1  raw hsync level (high = horizontal retrace)
- vsync_in  in  1  raw vsync level (high = vertical retrace)
- x  in  10  current pixel column
- y  in  10  current pixel row
- pause  in  1  freeze box motion while high
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- hsync  out  1  hsync delayed to match rgb
- vsync  out  1  vsync delayed to match rgb
- frame_tick  out  1  one-clk pulse at start of each vertical retrace
- box_x  out  10  current box top-left x
- box_y  out  10  current box top-left y

Behaviour:
- Reset (reset_n low, async, all registers):
  - rgb=0, hsync=0, vsync=0, frame_tick=0.
  - box_x=X0, box_y=Y0; direction right (dx=+) and down (dy=+).
  - Both pipeline stages cleared; vsync edge register=0.
- Frame tick:
  - vsync_d samples vsync_in every clk.
  - frame_tick = vsync_in & ~vsync_d, registered: high exactly one clk, one clk after the vsync_in rising edge.
- Motion, evaluated in the clk in which frame_tick is high, if pause=0; 11-bit arithmetic, no wrap:
  - x moving right: if box_x+SPEED >= H_DISPLAY-SIZE, then box_x <= H_DISPLAY-SIZE and dx flips to left; else box_x += SPEED.
  - x moving left: if box_x <= SPEED, then box_x <= 0 and dx flips to right; else box_x -= SPEED.
  - y: identical rules with V_DISPLAY and dy.
  - Both axes update in the same clk; a corner hit flips both directions.
- pause: pause=1 on a frame_tick clk means no position or direction change. Pause is sampled only at frame_tick.
- Pixel pipeline:
  - Two stages, both advancing only on clks where p_tick=1; hold otherwise.
  - S1 registers x, y, video_on, hsync_in, vsync_in.
  - S2 computes the colour from S1 and registers it to rgb, together with S1 hsync/vsync to hsync/vsync.
  - Latency: exactly 2 p_ticks from input to output.
- Colour priority at S2:
  1. video_on_s1=0 gives 0.
  2. Inside box (box_x <= x_s1 < box_x+SIZE and box_y <= y_s1 < box_y+SIZE) gives COLOR_BOX.
  3. x_s1==0, x_s1==H_DISPLAY-1, y_s1==0 or y_s1==V_DISPLAY-1 gives COLOR_BORDER.
  4. Otherwise COLOR_BG.
- Box position mid-frame: box moves only during vertical retrace, so the visible frame never tears. S2 uses the live box_x/box_y.
- Reset mid-frame: all outputs return to reset values immediately. The first frame_tick after release is the next vsync_in rising edge.
- vsync_in already high at reset release: no frame_tick until vsync_in goes low and rises again.

Decomposition:
- Package vga_pkg:
  - H_DISPLAY, V_DISPLAY and RGB_W=12.
  - Colour constants COLOR_BLACK/WHITE/RED/BLUE.
  - Direction encoding DIR_POS=1'b0, DIR_NEG=1'b1.
- One sub-module, vga_box_motion: frame-edge detector, direction registers and position update. Outputs frame_tick, box_x, box_y.
- The pixel pipeline and colour mux stay in the top module.

Test Plan:
- Reset, then X0=Y0=0, one vsync_in rise -> frame_tick high 1 clk; box_x=2, box_y=2 the next clk; rgb=0, hsync=vsync=0 during reset.
- X0=604, SIZE=32, SPEED=2, three frames -> box_x 606, 608 (dx flips left), 606.
- Y0=0, moving down then forced to dy=up; next frame -> box_y clamps 0, dy flips down.
- pause=1 across two vsync_in rises -> box_x/box_y unchanged; frame_tick still pulses.
- Box at (0,0), drive x=5, y=5, video_on=1, then two p_ticks -> rgb=12'hF00. Same for x=639, y=100 -> 12'hFFF. x=300, y=300 -> 12'h00F.
- video_on=0 with hsync_in=1 -> rgb=0 and hsync=1 exactly 2 p_ticks later. Outputs hold between p_ticks. Assert reset_n low mid-line -> rgb=0 in the same clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared display geometry, colour constants and direction encoding for the
// VGA box renderer slice.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int RGB_W     = 12;

    localparam logic [RGB_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] COLOR_WHITE = 12'hFFF;
    localparam logic [RGB_W-1:0] COLOR_RED   = 12'hF00;
    localparam logic [RGB_W-1:0] COLOR_BLUE  = 12'h00F;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/vga_box_renderer_if.sv
// Pixel-timing bus from the sync generator: coordinates, visible flag,
// pixel enable and the raw sync levels.
interface vga_box_renderer_if;

    logic       p_tick;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x;
    logic [9:0] y;

    modport master (output p_tick, video_on, hsync_in, vsync_in, x, y);
    modport slave  (input  p_tick, video_on, hsync_in, vsync_in, x, y);

endinterface

// File: rtl/vga_box_motion.sv
// Detects the start of vertical retrace and moves the box once per frame,
// bouncing off the screen edges.
module vga_box_motion #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int SIZE      = 32,
    parameter int SPEED     = 2,
    parameter int X0        = 0,
    parameter int Y0        = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync_in,
    input  logic       pause,
    output logic       frame_tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);
    import vga_pkg::*;

    localparam logic [10:0] X_MAX = 11'(H_DISPLAY - SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - SIZE);
    localparam logic [10:0] STEP  = 11'(SPEED);

    logic        vsync_d;
    logic        armed;
    dir_t        dx, dy;
    dir_t        next_dx, next_dy;
    logic [10:0] next_x, next_y;
    logic [10:0] cur_x, cur_y;

    assign cur_x = {1'b0, box_x};
    assign cur_y = {1'b0, box_y};

    always_comb begin
        next_x  = cur_x;
        next_y  = cur_y;
        next_dx = dx;
        next_dy = dy;
        if (dx == DIR_POS) begin
            if (cur_x + STEP >= X_MAX) begin
                next_x  = X_MAX;
                next_dx = DIR_NEG;
            end else begin
                next_x = cur_x + STEP;
            end
        end else begin
            if (cur_x <= STEP) begin
                next_x  = 11'd0;
                next_dx = DIR_POS;
            end else begin
                next_x = cur_x - STEP;
            end
        end
        if (dy == DIR_POS) begin
            if (cur_y + STEP >= Y_MAX) begin
                next_y  = Y_MAX;
                next_dy = DIR_NEG;
            end else begin
                next_y = cur_y + STEP;
            end
        end else begin
            if (cur_y <= STEP) begin
                next_y  = 11'd0;
                next_dy = DIR_POS;
            end else begin
                next_y = cur_y - STEP;
            end
        end
    end

    // armed blocks a false edge when vsync_in is already high at reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d    <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
            box_x      <= 10'(X0);
            box_y      <= 10'(Y0);
            dx         <= DIR_POS;
            dy         <= DIR_POS;
        end else begin
            vsync_d    <= vsync_in;
            armed      <= armed | ~vsync_in;
            frame_tick <= vsync_in & ~vsync_d & armed;
            if (frame_tick && !pause) begin
                box_x <= next_x[9:0];
                box_y <= next_y[9:0];
                dx    <= next_dx;
                dy    <= next_dy;
            end
        end
    end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage after the sync generator: draws a bouncing box over a bordered
// background and re-times the sync pulses to stay aligned with the colour.
module vga_box_renderer #(
    parameter int                           H_DISPLAY    = vga_pkg::H_DISPLAY,
    parameter int                           V_DISPLAY    = vga_pkg::V_DISPLAY,
    parameter int                           SIZE         = 32,
    parameter int                           SPEED        = 2,
    parameter int                           X0           = 0,
    parameter int                           Y0           = 0,
    parameter logic [vga_pkg::RGB_W-1:0]    COLOR_BOX    = vga_pkg::COLOR_RED,
    parameter logic [vga_pkg::RGB_W-1:0]    COLOR_BG     = vga_pkg::COLOR_BLUE,
    parameter logic [vga_pkg::RGB_W-1:0]    COLOR_BORDER = vga_pkg::COLOR_WHITE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    vga_box_renderer_if.slave         sync_bus,
    input  logic                      pause,
    output logic [vga_pkg::RGB_W-1:0] rgb,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      frame_tick,
    output logic [9:0]                box_x,
    output logic [9:0]                box_y
);
    import vga_pkg::*;

    logic [9:0]       x_s1, y_s1;
    logic             video_on_s1, hsync_s1, vsync_s1;
    logic             in_box, on_border;
    logic [RGB_W-1:0] pixel_color;

    vga_box_motion #(
        .H_DISPLAY (H_DISPLAY),
        .V_DISPLAY (V_DISPLAY),
        .SIZE      (SIZE),
        .SPEED     (SPEED),
        .X0        (X0),
        .Y0        (Y0)
    ) u_motion (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync_in   (sync_bus.vsync_in),
        .pause      (pause),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // Live box position is safe here: it only changes during vertical retrace
    always_comb begin
        in_box = ({1'b0, x_s1} >= {1'b0, box_x}) &&
                 ({1'b0, x_s1} <  {1'b0, box_x} + 11'(SIZE)) &&
                 ({1'b0, y_s1} >= {1'b0, box_y}) &&
                 ({1'b0, y_s1} <  {1'b0, box_y} + 11'(SIZE));
        on_border = (x_s1 == 10'd0) || (x_s1 == 10'(H_DISPLAY - 1)) ||
                    (y_s1 == 10'd0) || (y_s1 == 10'(V_DISPLAY - 1));
        pixel_color = COLOR_BG;
        if (!video_on_s1) begin
            pixel_color = COLOR_BLACK;
        end else if (in_box) begin
            pixel_color = COLOR_BOX;
        end else if (on_border) begin
            pixel_color = COLOR_BORDER;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_s1        <= '0;
            y_s1        <= '0;
            video_on_s1 <= 1'b0;
            hsync_s1    <= 1'b0;
            vsync_s1    <= 1'b0;
            rgb         <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
        end else if (sync_bus.p_tick) begin
            x_s1        <= sync_bus.x;
            y_s1        <= sync_bus.y;
            video_on_s1 <= sync_bus.video_on;
            hsync_s1    <= sync_bus.hsync_in;
            vsync_s1    <= sync_bus.vsync_in;
            rgb         <= pixel_color;
            hsync       <= hsync_s1;
            vsync       <= vsync_s1;
        end
    end

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed self-checking bench for vga_box_renderer: motion, bounce, pause,
// colour priority and sync re-timing.
module tb_vga_box_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pause;
    logic [11:0] rgb;
    logic        hsync, vsync, frame_tick;
    logic [9:0]  box_x, box_y;

    int errors = 0;
    int checks = 0;

    vga_box_renderer_if sync_bus ();

    vga_box_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_bus   (sync_bus.slave),
        .pause      (pause),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ptick();
        sync_bus.p_tick = 1'b1;
        step();
        sync_bus.p_tick = 1'b0;
        step();
    endtask

    task automatic run_frame(output logic saw);
        sync_bus.vsync_in = 1'b1;
        step();
        saw = frame_tick;
        step();
        sync_bus.vsync_in = 1'b0;
        step();
        step();
    endtask

    task automatic check_box(input string name, input int ex, input int ey);
        checks++;
        if (box_x !== 10'(ex) || box_y !== 10'(ey)) begin
            errors++;
            $display("[TB] FAIL %s: box=(%0d,%0d) expected (%0d,%0d)", name, box_x, box_y, ex, ey);
        end
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        pause             = 1'b0;
        sync_bus.p_tick   = 1'b1;
        sync_bus.video_on = 1'b1;
        sync_bus.hsync_in = 1'b1;
        sync_bus.vsync_in = 1'b0;
        sync_bus.x        = 10'd5;
        sync_bus.y        = 10'd5;
        repeat (3) step();
        checks++;
        if (rgb !== 12'h000 || hsync !== 1'b0 || vsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rgb=%h hsync=%b vsync=%b expected 000 0 0", rgb, hsync, vsync);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_tick: got %b expected 0", frame_tick);
        end
        check_box("reset_box", 0, 0);
        sync_bus.p_tick   = 1'b0;
        sync_bus.video_on = 1'b0;
        sync_bus.hsync_in = 1'b0;
        reset_n           = 1'b1;
        step();
        step();
    endtask

    task automatic test_frame_tick();
        sync_bus.vsync_in = 1'b1;
        step();
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_tick_high: got %b expected 1", frame_tick);
        end
        check_box("box_before_move", 0, 0);
        step();
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_tick_one_clk: got %b expected 0", frame_tick);
        end
        check_box("box_after_first_frame", 2, 2);
        sync_bus.vsync_in = 1'b0;
        step();
        step();
    endtask

    // Frames counted from reset; box is at (2,2) after frame 1
    task automatic test_bounce_x();
        logic saw;
        for (int i = 0; i < 301; i++) run_frame(saw);
        check_box("frame302", 604, 292);
        run_frame(saw);
        check_box("frame303", 606, 290);
        run_frame(saw);
        check_box("frame304_x_clamp", 608, 288);
        run_frame(saw);
        check_box("frame305_x_left", 606, 286);
    endtask

    task automatic test_bounce_y();
        logic saw;
        for (int i = 0; i < 141; i++) run_frame(saw);
        run_frame(saw);
        check_box("frame447", 322, 2);
        run_frame(saw);
        check_box("frame448_y_clamp", 320, 0);
        run_frame(saw);
        check_box("frame449_y_down", 318, 2);
    endtask

    task automatic test_pause();
        logic saw;
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_frame(saw);
            checks++;
            if (saw !== 1'b1) begin
                errors++;
                $display("[TB] FAIL pause_frame_tick%0d: got %b expected 1", i, saw);
            end
        end
        check_box("paused_box", 318, 2);
        pause = 1'b0;
        run_frame(saw);
        check_box("resumed_box", 316, 4);
    endtask

    task automatic test_vsync_high_at_release();
        logic seen;
        reset_n           = 1'b0;
        sync_bus.vsync_in = 1'b1;
        step();
        reset_n = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | frame_tick;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_tick_when_high_at_release: saw %b expected 0", seen);
        end
        sync_bus.vsync_in = 1'b0;
        step();
        sync_bus.vsync_in = 1'b1;
        step();
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tick_after_rearm: got %b expected 1", frame_tick);
        end
        step();
        check_box("box_after_rearm", 2, 2);
        sync_bus.vsync_in = 1'b0;
        step();
    endtask

    task automatic test_pixel_colours();
        logic [9:0]  vx [10] = '{10'd5, 10'd639, 10'd300, 10'd31, 10'd32, 10'd5, 10'd0, 10'd200, 10'd100, 10'd5};
        logic [9:0]  vy [10] = '{10'd5, 10'd100, 10'd300, 10'd31, 10'd5, 10'd32, 10'd200, 10'd479, 10'd0, 10'd5};
        logic        von[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] exp[10] = '{12'hF00, 12'hFFF, 12'h00F, 12'hF00, 12'h00F, 12'h00F, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            sync_bus.x        = vx[i];
            sync_bus.y        = vy[i];
            sync_bus.video_on = von[i];
            ptick();
            ptick();
            checks++;
            if (rgb !== exp[i]) begin
                errors++;
                $display("[TB] FAIL colour(%0d,%0d,von=%b): rgb=%h expected %h", vx[i], vy[i], von[i], rgb, exp[i]);
            end
        end
    endtask

    task automatic test_sync_pipeline();
        sync_bus.video_on = 1'b0;
        sync_bus.hsync_in = 1'b1;
        ptick();
        checks++;
        if (hsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hsync_after_1_tick: got %b expected 0", hsync);
        end
        ptick();
        checks++;
        if (hsync !== 1'b1 || rgb !== 12'h000) begin
            errors++;
            $display("[TB] FAIL hsync_after_2_ticks: hsync=%b rgb=%h expected 1 000", hsync, rgb);
        end
        sync_bus.hsync_in = 1'b0;
        repeat (3) step();
        checks++;
        if (hsync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hsync_hold: got %b expected 1", hsync);
        end
        sync_bus.video_on = 1'b1;
        sync_bus.x        = 10'd5;
        sync_bus.y        = 10'd5;
        ptick();
        ptick();
        sync_bus.x = 10'd300;
        sync_bus.y = 10'd300;
        repeat (3) step();
        checks++;
        if (rgb !== 12'hF00) begin
            errors++;
            $display("[TB] FAIL rgb_hold: got %h expected F00", rgb);
        end
        sync_bus.vsync_in = 1'b1;
        ptick();
        checks++;
        if (vsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vsync_after_1_tick: got %b expected 0", vsync);
        end
        ptick();
        checks++;
        if (vsync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL vsync_after_2_ticks: got %b expected 1", vsync);
        end
        sync_bus.vsync_in = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        sync_bus.x        = 10'd5;
        sync_bus.y        = 10'd5;
        sync_bus.video_on = 1'b1;
        sync_bus.hsync_in = 1'b1;
        ptick();
        ptick();
        checks++;
        if (rgb !== 12'hF00 || hsync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_line: rgb=%h hsync=%b expected F00 1", rgb, hsync);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rgb !== 12'h000 || hsync !== 1'b0 || vsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: rgb=%h hsync=%b vsync=%b expected 000 0 0", rgb, hsync, vsync);
        end
        check_box("async_reset_box", 0, 0);
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_bounce_x();
        test_bounce_y();
        test_pause();
        test_vsync_high_at_release();
        test_pixel_colours();
        test_sync_pipeline();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
